icc_branch_unit: RTL and testbench

- Consumer end of the integer ALU's condition-code interface.
- Latches the N/Z/V/C flags into the integer condition-code register (icc) whenever a flag-setting (S-bit) operation completes.
- Evaluates SPARC V8 Bicc conditions against icc, computes the branch target, and sequences the delay slot, including annulment.
- Sits between the ALU flag outputs and the fetch/PC-redirect logic.

---
 rtl/icc_branch_unit.sv | 163 ++++++++++++++++
 tb/tb_icc_branch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/icc_branch_unit.sv
// rtl/icc_branch_unit.sv - SPARC V8 integer condition codes, Bicc evaluation and delay-slot sequencing
//
// Holds the {N,Z,V,C} condition-code register written by flag-setting ALU ops,
// evaluates Bicc conditions (forwarding same-cycle ALU flags), computes the
// branch target and tracks the delay slot, including annulment.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   icc_we, alu_n/z/v/c   ALU flag write strobe and flags
//   br_valid, br_cond,
//   br_a, br_disp, br_pc  Bicc instruction presented this cycle
//   insn_valid            delay-slot instruction presented this cycle
//   icc                   current {N,Z,V,C}
//   redirect              one-cycle pulse, branch taken
//   target                branch target of the last accepted branch
//   annul                 squash the delay-slot instruction now presented
//   busy                  waiting for the delay slot
//   dcti_err              one-cycle pulse, branch seen in the delay slot
module icc_branch_unit #(
    parameter int DISP_W = 22,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icc_we,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_c,
    input  logic              br_valid,
    input  logic [3:0]        br_cond,
    input  logic              br_a,
    input  logic [DISP_W-1:0] br_disp,
    input  logic [PC_W-1:0]   br_pc,
    input  logic              insn_valid,
    output logic [3:0]        icc,
    output logic              redirect,
    output logic [PC_W-1:0]   target,
    output logic              annul,
    output logic              busy,
    output logic              dcti_err
);

    localparam int EXT_W = PC_W - DISP_W - 2;

    localparam logic [3:0] COND_BN = 4'd0;
    localparam logic [3:0] COND_BA = 4'd8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DELAY = 2'd1,
        ST_ANNUL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        icc_q, icc_d;
    logic              redirect_q, redirect_d;
    logic [PC_W-1:0]   target_q, target_d;
    logic              dcti_err_q, dcti_err_d;

    logic [3:0]        alu_flags;
    logic [3:0]        eval_flags;
    logic              f_n, f_z, f_v, f_c;
    logic              taken;
    logic              accept;
    logic [PC_W-1:0]   br_target;

    assign alu_flags  = {alu_n, alu_z, alu_v, alu_c};
    // A flag-setting op completing this cycle is forwarded to the branch.
    assign eval_flags = icc_we ? alu_flags : icc_q;
    assign f_n = eval_flags[3];
    assign f_z = eval_flags[2];
    assign f_v = eval_flags[1];
    assign f_c = eval_flags[0];

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            4'd0:    taken = 1'b0;
            4'd1:    taken = f_z;
            4'd2:    taken = f_z | (f_n ^ f_v);
            4'd3:    taken = f_n ^ f_v;
            4'd4:    taken = f_c | f_z;
            4'd5:    taken = f_c;
            4'd6:    taken = f_n;
            4'd7:    taken = f_v;
            4'd8:    taken = 1'b1;
            4'd9:    taken = ~f_z;
            4'd10:   taken = ~(f_z | (f_n ^ f_v));
            4'd11:   taken = ~(f_n ^ f_v);
            4'd12:   taken = ~(f_c | f_z);
            4'd13:   taken = ~f_c;
            4'd14:   taken = ~f_n;
            4'd15:   taken = ~f_v;
            default: taken = 1'b0;
        endcase
    end

    // Word displacement: sign-extend and scale by 4; the add wraps mod 2^PC_W.
    assign br_target = br_pc + {{EXT_W{br_disp[DISP_W-1]}}, br_disp, 2'b00};

    assign accept = br_valid && (state_q == ST_RUN);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            icc_q      <= 4'b0000;
            redirect_q <= 1'b0;
            target_q   <= '0;
            dcti_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            icc_q      <= icc_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            dcti_err_q <= dcti_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        icc_d      = icc_we ? alu_flags : icc_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        dcti_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    redirect_d = taken;
                    target_d   = br_target;
                    // Annul bit squashes the slot for untaken branches and for BA;
                    // BN is never taken so it is covered by the first term.
                    if (br_a && (!taken || br_cond == COND_BA || br_cond == COND_BN)) begin
                        state_d = ST_ANNUL;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end
            end
            ST_DELAY, ST_ANNUL: begin
                // A branch in the delay slot is flagged but never evaluated.
                dcti_err_d = br_valid;
                if (insn_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outputs
    always_comb begin
        icc      = icc_q;
        redirect = redirect_q;
        target   = target_q;
        dcti_err = dcti_err_q;
        busy     = (state_q != ST_RUN);
        annul    = (state_q == ST_ANNUL);
    end

endmodule

// File: tb/tb_icc_branch_unit.sv
// tb/tb_icc_branch_unit.sv - self-checking bench for icc_branch_unit
module tb_icc_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        icc_we = 1'b0;
    logic        alu_n = 1'b0, alu_z = 1'b0, alu_v = 1'b0, alu_c = 1'b0;
    logic        br_valid = 1'b0;
    logic [3:0]  br_cond = 4'd0;
    logic        br_a = 1'b0;
    logic [21:0] br_disp = 22'd0;
    logic [31:0] br_pc = 32'd0;
    logic        insn_valid = 1'b0;
    logic [3:0]  icc;
    logic        redirect;
    logic [31:0] target;
    logic        annul;
    logic        busy;
    logic        dcti_err;

    int errors = 0;
    int checks = 0;

    icc_branch_unit #(.DISP_W(22), .PC_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .icc_we(icc_we),
        .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .br_valid(br_valid), .br_cond(br_cond), .br_a(br_a),
        .br_disp(br_disp), .br_pc(br_pc), .insn_valid(insn_valid),
        .icc(icc), .redirect(redirect), .target(target),
        .annul(annul), .busy(busy), .dcti_err(dcti_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending = 0 idle, 1 delay slot runs, 2 delay slot squashed.
    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, v, cy, r;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[2:0])
            3'd0: r = 0;
            3'd1: r = z;
            3'd2: r = z | (n ^ v);
            3'd3: r = n ^ v;
            3'd4: r = cy | z;
            3'd5: r = cy;
            3'd6: r = n;
            default: r = v;
        endcase
        return c[3] ? !r : r;
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [21:0] d);
        longint sd;
        sd = d[21] ? longint'(d) - 64'sd4194304 : longint'(d);
        return 32'(longint'(pc) + sd * 4);
    endfunction

    logic [3:0]  m_icc = 4'd0;
    bit          m_redirect = 0;
    logic [31:0] m_target = 32'd0;
    bit          m_dcti = 0;
    int          m_pending = 0;
    logic [3:0]  m_f;
    bit          m_tk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_icc = 0; m_redirect = 0; m_target = 0; m_dcti = 0; m_pending = 0;
        end else begin
            m_f = icc_we ? {alu_n, alu_z, alu_v, alu_c} : m_icc;
            m_redirect = 0;
            m_dcti = 0;
            if (m_pending == 0) begin
                if (br_valid) begin
                    m_tk = cond_true(br_cond, m_f);
                    m_redirect = m_tk;
                    m_target = branch_target(br_pc, br_disp);
                    m_pending = (br_a && (!m_tk || br_cond == 4'd8)) ? 2 : 1;
                end
            end else begin
                m_dcti = br_valid;
                if (insn_valid) m_pending = 0;
            end
            if (icc_we) m_icc = {alu_n, alu_z, alu_v, alu_c};
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_icc", {28'd0, icc}, {28'd0, m_icc});
            chk("m_redirect", {31'd0, redirect}, {31'd0, m_redirect});
            chk("m_target", target, m_target);
            chk("m_busy", {31'd0, busy}, {31'd0, m_pending != 0});
            chk("m_annul", {31'd0, annul}, {31'd0, m_pending == 2});
            chk("m_dcti_err", {31'd0, dcti_err}, {31'd0, m_dcti});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        icc_we = 0; br_valid = 0; insn_valid = 0; br_a = 0;
    endtask

    task automatic set_icc(input logic [3:0] f);
        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = f;
        cyc();
        icc_we = 0;
    endtask

    task automatic branch(input logic [3:0] c, input logic a, input logic [31:0] pc, input logic [21:0] d);
        br_valid = 1; br_cond = c; br_a = a; br_pc = pc; br_disp = d;
    endtask

    logic [31:0] saved_target;

    initial begin
        // Reset state
        cyc(); cyc();
        chk("reset_icc", {28'd0, icc}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_target", target, 32'd0);
        reset_n = 1;
        cyc();

        // BE with forwarded Z flag
        icc_we = 1; {alu_n, alu_z, alu_v, alu_c} = 4'b0100;
        branch(4'd1, 0, 32'h1000, 22'h000004);
        cyc(); idle_in();
        chk("be_redirect", {31'd0, redirect}, 32'd1);
        chk("be_target", target, 32'h1010);
        chk("be_busy", {31'd0, busy}, 32'd1);
        chk("be_annul", {31'd0, annul}, 32'd0);
        chk("be_icc", {28'd0, icc}, 32'h4);
        cyc();
        chk("be_redirect_pulse", {31'd0, redirect}, 32'd0);
        insn_valid = 1; cyc(); insn_valid = 0;
        chk("be_busy_done", {31'd0, busy}, 32'd0);

        // BGE not taken with annul, negative displacement
        set_icc(4'b1000);
        branch(4'hB, 1, 32'h2000, 22'h3FFFFF);
        cyc(); idle_in();
        chk("bge_redirect", {31'd0, redirect}, 32'd0);
        chk("bge_target", target, 32'h1FFC);
        chk("bge_annul", {31'd0, annul}, 32'd1);
        cyc();
        chk("bge_annul_hold", {31'd0, annul}, 32'd1);
        insn_valid = 1; cyc(); insn_valid = 0;
        chk("bge_annul_done", {31'd0, annul}, 32'd0);

        // BA with annul, target wraps
        branch(4'd8, 1, 32'hFFFFFFFC, 22'd1);
        cyc(); idle_in();
        chk("ba_a_redirect", {31'd0, redirect}, 32'd1);
        chk("ba_a_target", target, 32'h0);
        chk("ba_a_annul", {31'd0, annul}, 32'd1);
        insn_valid = 1; cyc(); insn_valid = 0;

        // BA without annul, then a branch in the delay slot
        branch(4'd8, 0, 32'h4000, 22'h10);
        cyc(); idle_in();
        chk("ba_redirect", {31'd0, redirect}, 32'd1);
        chk("ba_annul", {31'd0, annul}, 32'd0);
        saved_target = target;
        branch(4'd8, 0, 32'h8000, 22'h20);
        insn_valid = 1;
        cyc(); idle_in();
        chk("dcti_pulse", {31'd0, dcti_err}, 32'd1);
        chk("dcti_busy", {31'd0, busy}, 32'd0);
        chk("dcti_target", target, saved_target);
        chk("dcti_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        chk("dcti_clear", {31'd0, dcti_err}, 32'd0);

        // Sweep every condition against every icc value
        for (int f = 0; f < 16; f++) begin
            set_icc(4'(f));
            for (int c = 0; c < 16; c++) begin
                branch(4'(c), 0, 32'h100, 22'h8);
                cyc(); idle_in();
                chk("sweep_redirect", {31'd0, redirect}, {31'd0, cond_true(4'(c), 4'(f))});
                for (int k = 0; k < 3; k++) begin
                    chk("sweep_busy", {31'd0, busy}, 32'd1);
                    cyc();
                end
                insn_valid = 1; cyc(); insn_valid = 0;
            end
        end

        // Asynchronous reset while in the delay slot
        set_icc(4'b1111);
        branch(4'd8, 0, 32'h500, 22'h1);
        cyc(); idle_in();
        #1 reset_n = 0;
        #1;
        chk("async_icc", {28'd0, icc}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_annul", {31'd0, annul}, 32'd0);
        chk("async_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        reset_n = 1;
        cyc();

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            icc_we     = ($urandom_range(0, 3) == 0);
            {alu_n, alu_z, alu_v, alu_c} = 4'($urandom);
            br_valid   = ($urandom_range(0, 2) == 0);
            br_cond    = 4'($urandom);
            br_a       = 1'($urandom);
            br_disp    = 22'($urandom);
            br_pc      = $urandom;
            insn_valid = ($urandom_range(0, 2) == 0);
            cyc();
        end
        idle_in();
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
